// File: rtl/s_link_pkg.sv
// Shared definitions for the S-link TX frame builder: command codes, markers, FSM states.
package s_link_pkg;

  localparam logic [7:0] CMD_PING_REQ   = 8'h01;
  localparam logic [7:0] CMD_PING_RESP  = 8'h10;
  localparam logic [7:0] CMD_READY_REQ  = 8'h02;
  localparam logic [7:0] CMD_READY_RESP = 8'h20;
  localparam logic [7:0] CMD_WR_REQ     = 8'h70;
  localparam logic [7:0] CMD_RD_REQ     = 8'h90;

  localparam logic [15:0] MARK_ZERO = 16'hA55A;
  localparam logic [15:0] MARK_NWR  = 16'h55AA;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_HEAD, S_BODY, S_CSUM, S_START
  } state_t;

  function automatic logic [15:0] marker(input logic [3:0] cnt, input logic [3:0] num_wr);
    if (cnt == 4'd0)        return MARK_ZERO;
    else if (cnt == num_wr) return MARK_NWR;
    else                    return 16'h0000;
  endfunction

endpackage

// File: rtl/s_link_rd_pipe.sv
// Delay line aligning TX data buffer read strobes and target frame addresses with read data.
module s_link_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int AW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr
);

  logic [RD_LAT:1]         vld_pipe;
  logic [RD_LAT:1][AW-1:0] addr_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= in_vld;
      addr_pipe[1] <= in_addr;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[RD_LAT];
  assign out_addr = addr_pipe[RD_LAT];

endmodule

// File: rtl/s_link_tx_framer.sv
// S-link TX frame builder: header + body into frame RAM, then a serialiser start pulse.
// Optional trailing checksum byte when S_LINK_TX_CSUM_EN is defined.
module s_link_tx_framer
  import s_link_pkg::*;
#(
  parameter int         HEAD_LEN  = 5,
  parameter int         ADDR_W    = 16,
  parameter int         BUF_AW    = 11,
  parameter int         BLK_LEN   = 1024,
  parameter int         SHORT_LEN = 16,
  parameter logic [7:0] FILL_BYTE = 8'h5A,
  parameter int         NUM_WR    = 2,
  parameter int         RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ini_dvalid,
  input  logic [7:0]        i_ini_data,
  input  logic              i_tx_en,
  input  logic [7:0]        i_tx_cmd,
  input  logic [ADDR_W-1:0] i_tx_addr,
  output logic              o_tx_busy,
  output logic              o_tx_done,
  output logic              o_sl_txbuf_rden,
  output logic [BUF_AW-1:0] o_sl_txbuf_raddr,
  input  logic [7:0]        i_sl_txbuf_rdata,
  output logic              o_tx_start,
  output logic [BUF_AW-1:0] o_tx_data_len,
  output logic              o_txbuf_wren,
  output logic [BUF_AW-1:0] o_txbuf_waddr,
  output logic [7:0]        o_txbuf_wdata
);

`ifdef S_LINK_TX_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int CW         = BUF_AW + 1;
  localparam int LONG_FLEN  = HEAD_LEN + BLK_LEN + CS;
  localparam int SHORT_FLEN = HEAD_LEN + SHORT_LEN + CS;

  if (HEAD_LEN < 5) begin : g_bad_head
    $error("HEAD_LEN must be >= 5");
  end
  if (LONG_FLEN > 2**BUF_AW || SHORT_FLEN > 2**BUF_AW) begin : g_bad_len
    $error("frame length exceeds frame RAM");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("RD_LAT must be 1..4");
  end

  state_t                  state, state_n;
  logic [31:0]             ver;
  logic [3:0]              cnt;
  logic [7:0]              cmd_q;
  logic [15:0]             addr_q;
  logic                    long_q;
  logic [HEAD_LEN*8-1:0]   hdr, hdr_n;
  logic [CW-1:0]           idx;
  logic [BUF_AW-1:0]       raddr, tgt_addr, paddr, data_len;
  logic [7:0]              csum;
  logic                    accept, rden, pv, last_wr;
  logic                    wren;
  logic [BUF_AW-1:0]       waddr;
  logic [7:0]              wdata;

  assign accept   = (state == S_IDLE) && i_tx_en;
  assign tgt_addr = BUF_AW'(HEAD_LEN) + idx[BUF_AW-1:0];

  // Header image, MSB first; marker uses the counter value already updated at acceptance.
  always_comb begin
    hdr_n = '0;
    hdr_n[HEAD_LEN*8-1 -: 8] = cmd_q;
    if (cmd_q == CMD_PING_REQ) hdr_n[HEAD_LEN*8-9 -: 32] = ver;
    else if (long_q)           hdr_n[HEAD_LEN*8-9 -: 32] = {addr_q, marker(cnt, 4'(NUM_WR))};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ver      <= '0;
      cnt      <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      long_q   <= 1'b0;
      hdr      <= '0;
      idx      <= '0;
      raddr    <= '0;
      csum     <= '0;
      data_len <= '0;
    end else begin
      state <= state_n;
      if (i_ini_dvalid) ver <= {ver[23:0], i_ini_data};
      if (accept) begin
        cmd_q  <= i_tx_cmd;
        addr_q <= 16'(i_tx_addr);
        raddr  <= i_tx_addr[BUF_AW-1:0];
        long_q <= (i_tx_cmd == CMD_WR_REQ) || (i_tx_cmd == CMD_RD_REQ);
        case (i_tx_cmd)
          CMD_PING_REQ, CMD_PING_RESP: cnt <= '0;
          CMD_WR_REQ, CMD_RD_REQ:      cnt <= cnt + 4'd1;
          default: ;
        endcase
      end
      if (wren && state != S_CSUM) csum <= csum + wdata;
      case (state)
        S_LATCH: begin
          hdr  <= hdr_n;
          idx  <= '0;
          csum <= '0;
        end
        S_HEAD: begin
          hdr <= hdr << 8;
          idx <= (state_n == S_BODY) ? '0 : idx + 1'b1;
        end
        S_BODY: begin
          if (!long_q || rden) idx <= idx + 1'b1;
          if (rden) raddr <= raddr + 1'b1;
        end
        default: ;
      endcase
      if (state_n == S_START && state != S_START)
        data_len <= long_q ? BUF_AW'(LONG_FLEN) : BUF_AW'(SHORT_FLEN);
    end
  end

  always_comb begin
    state_n = state;
    rden    = 1'b0;
    wren    = 1'b0;
    waddr   = '0;
    wdata   = '0;
    last_wr = 1'b0;
    case (state)
      S_IDLE:  if (i_tx_en) state_n = S_LATCH;
      S_LATCH: state_n = S_HEAD;
      S_HEAD: begin
        wren  = 1'b1;
        waddr = idx[BUF_AW-1:0];
        wdata = hdr[HEAD_LEN*8-1 -: 8];
        if (idx == CW'(HEAD_LEN-1)) state_n = S_BODY;
      end
      S_BODY: begin
        if (long_q) begin
          // reads run ahead; writes follow as the delayed data arrives
          rden    = idx < CW'(BLK_LEN);
          wren    = pv;
          waddr   = paddr;
          wdata   = i_sl_txbuf_rdata;
          last_wr = pv && (paddr == BUF_AW'(HEAD_LEN+BLK_LEN-1));
        end else begin
          wren    = 1'b1;
          waddr   = tgt_addr;
          wdata   = FILL_BYTE;
          last_wr = idx == CW'(SHORT_LEN-1);
        end
`ifdef S_LINK_TX_CSUM_EN
        if (last_wr) state_n = S_CSUM;
`else
        if (last_wr) state_n = S_START;
`endif
      end
      S_CSUM: begin
        wren    = 1'b1;
        waddr   = long_q ? BUF_AW'(HEAD_LEN+BLK_LEN) : BUF_AW'(HEAD_LEN+SHORT_LEN);
        wdata   = csum;
        state_n = S_START;
      end
      S_START: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  s_link_rd_pipe #(.RD_LAT(RD_LAT), .AW(BUF_AW)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rden),
    .in_addr  (tgt_addr),
    .out_vld  (pv),
    .out_addr (paddr)
  );

  assign o_tx_busy        = state != S_IDLE;
  assign o_tx_start       = state == S_START;
  assign o_tx_done        = state == S_START;
  assign o_tx_data_len    = data_len;
  assign o_sl_txbuf_rden  = rden;
  assign o_sl_txbuf_raddr = raddr;
  assign o_txbuf_wren     = wren;
  assign o_txbuf_waddr    = waddr;
  assign o_txbuf_wdata    = wdata;

endmodule
